// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared constants and state type for the instruction-fetch stage
//
// Purpose: default widths, opcode field location, HALT/NOP encodings and the
//          fetch FSM state type used by pc_fetch and its interface.
// Ports:   none (package).
package fetch_pkg;

  localparam int DEF_PC_W    = 10;
  localparam int DEF_INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0]  HALT_OPC  = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - fetch-stage bus: hazard/branch inputs, imem port and IF/ID outputs
//
// Purpose: groups every non-clock signal of pc_fetch.
// Signals: stall, branch_taken, branch_target  - control from hazard unit / branch stage
//          imem_addr, imem_rdata                - combinational instruction-memory port
//          if_valid, if_instr, if_pc            - IF/ID pipeline register
//          halted                               - fetch stopped on HALT
// Modports: master = fetch stage, slave = surrounding pipeline / memory.
interface pc_fetch_if
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_valid, if_instr, if_pc, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_valid, if_instr, if_pc, halted
  );

endinterface

// File: rtl/pc_fetch_sat_counter16.sv
// rtl/pc_fetch_sat_counter16.sv - 16-bit saturating event counter
//
// Purpose: counts enabled cycles, sticks at 16'hFFFF.
// Ports:   clk      - clock
//          rst      - asynchronous active-high reset (clears count)
//          i_inc    - increment enable
//          o_count  - current count
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 16'h0000;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction-fetch stage: PC register, imem addressing, IF/ID register
//
// Purpose: holds the PC, addresses instruction memory with it, and loads the
//          fetched word plus its PC into IF/ID. Branch redirects flush one slot;
//          a HALT opcode stops fetch until the next taken branch.
// Ports:   clk        - clock, rising edge
//          reset      - asynchronous active-high reset
//          bus        - pc_fetch_if.master (control in, imem port, IF/ID out, halted)
//          fetch_cnt  - valid-load counter   (only with PC_FETCH_PERF_EN)
//          bubble_cnt - bubble-load counter  (only with PC_FETCH_PERF_EN)
// Option:  PC_FETCH_PERF_EN adds the two saturating performance counters.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset,
  pc_fetch_if.master  bus
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;

  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_nxt;

  logic                 r_if_valid;
  logic [INSTR_W-1:0]   r_if_instr;
  logic [PC_W-1:0]      r_if_pc;

  logic                 w_ifid_load;
  logic                 w_ifid_valid_nxt;
  logic [INSTR_W-1:0]   w_ifid_instr_nxt;
  logic [PC_W-1:0]      w_ifid_pc_nxt;

  logic                 w_is_halt;

  assign w_is_halt = (bus.imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and IF/ID load decisions. A bubble always records the PC
  // current at the edge, so a flushed slot still shows where fetch was.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_load      = 1'b0;
    w_ifid_valid_nxt = 1'b0;
    w_ifid_instr_nxt = INSTR_W'(NOP_INSTR);
    w_ifid_pc_nxt    = r_pc;

    case (r_state)
      BOOT: begin
        // Single settling cycle: branch and stall are both ignored here.
        w_ifid_load = 1'b1;
        w_state_nxt = RUN;
      end

      RUN, HALTED: begin
        if (bus.branch_taken) begin
          w_pc_nxt    = bus.branch_target;
          w_ifid_load = 1'b1;
          w_state_nxt = RUN;
        end else if (bus.stall) begin
          w_ifid_load = 1'b0;
        end else if (r_state == RUN) begin
          w_ifid_load      = 1'b1;
          w_ifid_valid_nxt = 1'b1;
          w_ifid_instr_nxt = bus.imem_rdata;
          if (w_is_halt) begin
            // HALT is delivered downstream but fetch parks on its address.
            w_state_nxt = HALTED;
          end else begin
            w_pc_nxt = r_pc + PC_ONE;
          end
        end else begin
          w_ifid_load = 1'b1;
        end
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ifid_load) begin
        r_if_valid <= w_ifid_valid_nxt;
        r_if_instr <= w_ifid_instr_nxt;
        r_if_pc    <= w_ifid_pc_nxt;
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;
  assign bus.halted    = (r_state == HALTED);

`ifdef PC_FETCH_PERF_EN
  logic w_fetch_inc;
  logic w_bubble_inc;

  assign w_fetch_inc  = w_ifid_load &  w_ifid_valid_nxt;
  assign w_bubble_inc = w_ifid_load & ~w_ifid_valid_nxt;

  sat_counter16 u_fetch_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_fetch_inc),
    .o_count (fetch_cnt)
  );

  sat_counter16 u_bubble_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_bubble_inc),
    .o_count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic clk;
  logic reset;

  int n_cmp;
  int n_bad;

  logic [15:0] rom [0:1023];

`ifdef PC_FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;
`endif

  pc_fetch_if #(.PC_W(10), .INSTR_W(16)) bus ();

  pc_fetch #(.PC_W(10), .INSTR_W(16), .RESET_PC(10'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  assign bus.imem_rdata = rom[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic v, input logic [15:0] instr,
                          input logic [9:0] pc, input logic [9:0] addr, input logic h);
    check({tag, ".valid"},  32'(bus.if_valid),  32'(v));
    check({tag, ".instr"},  32'(bus.if_instr),  32'(instr));
    check({tag, ".pc"},     32'(bus.if_pc),     32'(pc));
    check({tag, ".addr"},   32'(bus.imem_addr), 32'(addr));
    check({tag, ".halted"}, 32'(bus.halted),    32'(h));
  endtask

  task automatic check_cnt(input string tag, input int f, input int b);
`ifdef PC_FETCH_PERF_EN
    check({tag, ".fetch_cnt"},  32'(fetch_cnt),  32'(f));
    check({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(b));
`else
    if (f < 0 || b < 0) $display("note %s: negative count request", tag);
`endif
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h1000 + 16'(i);
    rom[20] = 16'hF000;

    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 10'd0;

    #3;
    check_if("reset", 1'b0, 16'h0000, 10'd0, 10'd0, 1'b0);
    check_cnt("reset", 0, 0);
    #9;
    reset = 1'b0;

    // BOOT bubble, then sequential fetch 0..4.
    step();
    check_if("boot", 1'b0, 16'h0000, 10'd0, 10'd0, 1'b0);
    check_cnt("boot", 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_if("seq", 1'b1, 16'h1000 + 16'(i), 10'(i), 10'(i + 1), 1'b0);
    end
    check_cnt("seq", 5, 1);

    // Branch to 100 while addressing PC 5.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd100;
    step();
    bus.branch_taken  = 1'b0;
    check_if("br100_bubble", 1'b0, 16'h0000, 10'd5, 10'd100, 1'b0);
    check_cnt("br100_bubble", 5, 2);
    step();
    check_if("br100_tgt", 1'b1, 16'h1064, 10'd100, 10'd101, 1'b0);

    // Reposition to 6, fetch 6 and 7, then stall 3 cycles at if_pc 7.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd6;
    step();
    bus.branch_taken  = 1'b0;
    step();
    step();
    check_if("pre_stall", 1'b1, 16'h1007, 10'd7, 10'd8, 1'b0);
    check_cnt("pre_stall", 8, 3);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_if("stall", 1'b1, 16'h1007, 10'd7, 10'd8, 1'b0);
      check_cnt("stall", 8, 3);
    end
    bus.stall = 1'b0;
    step();
    check_if("post_stall", 1'b1, 16'h1008, 10'd8, 10'd9, 1'b0);

    // Stall and branch together: branch wins.
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd50;
    step();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    check_if("stbr_bubble", 1'b0, 16'h0000, 10'd9, 10'd50, 1'b0);
    step();
    check_if("stbr_tgt", 1'b1, 16'h1032, 10'd50, 10'd51, 1'b0);
    check_cnt("stbr_tgt", 10, 4);

    // HALT at address 20.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd19;
    step();
    bus.branch_taken  = 1'b0;
    check_if("pre_halt_bubble", 1'b0, 16'h0000, 10'd51, 10'd19, 1'b0);
    step();
    check_if("pre_halt", 1'b1, 16'h1013, 10'd19, 10'd20, 1'b0);
    step();
    check_if("halt_load", 1'b1, 16'hF000, 10'd20, 10'd20, 1'b1);
    check_cnt("halt_load", 12, 5);
    step();
    check_if("halted1", 1'b0, 16'h0000, 10'd20, 10'd20, 1'b1);
    step();
    check_if("halted2", 1'b0, 16'h0000, 10'd20, 10'd20, 1'b1);
    check_cnt("halted2", 12, 7);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd0;
    step();
    bus.branch_taken  = 1'b0;
    check_if("unhalt_bubble", 1'b0, 16'h0000, 10'd20, 10'd0, 1'b0);
    step();
    check_if("unhalt_tgt", 1'b1, 16'h1000, 10'd0, 10'd1, 1'b0);
    check_cnt("unhalt_tgt", 13, 8);

    // PC wrap 1022 -> 1023 -> 0.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd1022;
    step();
    bus.branch_taken  = 1'b0;
    check_if("wrap_bubble", 1'b0, 16'h0000, 10'd1, 10'd1022, 1'b0);
    step();
    check_if("wrap1022", 1'b1, 16'h13FE, 10'd1022, 10'd1023, 1'b0);
    step();
    check_if("wrap1023", 1'b1, 16'h13FF, 10'd1023, 10'd0, 1'b0);
    step();
    check_if("wrap0", 1'b1, 16'h1000, 10'd0, 10'd1, 1'b0);
    check_cnt("wrap0", 16, 9);

    // Asynchronous reset mid-run, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_if("async_rst", 1'b0, 16'h0000, 10'd0, 10'd0, 1'b0);
    check_cnt("async_rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_if("reboot", 1'b0, 16'h0000, 10'd0, 10'd0, 1'b0);
    step();
    check_if("reboot_first", 1'b1, 16'h1000, 10'd0, 10'd1, 1'b0);
    check_cnt("reboot_first", 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
